// File: rtl/id_ex_stage_pkg.sv
// Shared types and opcode constants for the RV32I ID/EX stage: writeback and
// forwarding select codes, the ID/EX control bundle and per-opcode source usage.
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        NO_WRITEBACK      = 2'd0,
        ALU_RESULT_SELECT = 2'd1,
        MEM_RESULT_SELECT = 2'd2,
        PC_PLUS4_SELECT   = 2'd3
    } write_back_mux_selector;

    // Code 2'd3 is deliberately unassigned and falls back to the register-file value.
    typedef enum logic [1:0] {
        NO_FORWARD_SELECT = 2'd0,
        EX_RESULT_SELECT  = 2'd1,
        WB_RESULT_SELECT  = 2'd2
    } forward_mux_code;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef struct packed {
        logic                   valid;
        logic [6:0]             opcode;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        write_back_mux_selector wb_mux;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t BUBBLE_CTRL = '{
        valid:  1'b0,
        opcode: 7'd0,
        rs1:    5'd0,
        rs2:    5'd0,
        rd:     5'd0,
        wb_mux: NO_WRITEBACK
    };

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD,
            OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR: uses_rs1 = 1'b1;
            default:                                  uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: uses_rs2 = 1'b1;
            default:                                uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// EX-stage operand forwarding mux: picks the EX/MEM result, the MEM/WB value
// or the registered register-file read according to a forward_mux_code.
module operand_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  forward_mux_code   sel,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [XLEN-1:0]   ex_mem_result,
    input  logic [XLEN-1:0]   mem_wb_result,
    output logic [XLEN-1:0]   operand
);

    // NOTE: the default arm assigns on every path, so no latch is inferred.
    always_comb begin
        case (sel)
            EX_RESULT_SELECT: operand = ex_mem_result;
            WB_RESULT_SELECT: operand = mem_wb_result;
            default:          operand = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX operand forwarding
// and saturating stall/flush performance counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid_ip,
    input  logic [6:0]             id_opcode_ip,
    input  logic [4:0]             id_rs1_ip,
    input  logic [4:0]             id_rs2_ip,
    input  logic [4:0]             id_rd_ip,
    input  logic [XLEN-1:0]        id_rs1_data_ip,
    input  logic [XLEN-1:0]        id_rs2_data_ip,
    input  logic [XLEN-1:0]        id_imm_ip,
    input  logic [XLEN-1:0]        id_pc_ip,
    input  write_back_mux_selector id_wb_mux_ip,
    input  logic                   flush_ip,
    input  logic                   hold_ip,
    input  forward_mux_code        fa_mux_ip,
    input  forward_mux_code        fb_mux_ip,
    input  logic [XLEN-1:0]        ex_mem_result_ip,
    input  logic [XLEN-1:0]        mem_wb_result_ip,
    output logic                   ex_valid_op,
    output logic [6:0]             ex_opcode_op,
    output logic [4:0]             ex_rs1_op,
    output logic [4:0]             ex_rs2_op,
    output logic [4:0]             ex_rd_op,
    output write_back_mux_selector ex_wb_mux_op,
    output logic [XLEN-1:0]        ex_imm_op,
    output logic [XLEN-1:0]        ex_pc_op,
    output logic [XLEN-1:0]        ex_rs1_val_op,
    output logic [XLEN-1:0]        ex_rs2_val_op,
    output logic                   stall_op,
    output logic [CNT_WIDTH-1:0]   stall_cnt_op,
    output logic [CNT_WIDTH-1:0]   flush_cnt_op
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    id_ex_ctrl_t           ctrl_q;
    logic [XLEN-1:0]       imm_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       rs1_data_q;
    logic [XLEN-1:0]       rs2_data_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;
    logic [CNT_WIDTH-1:0]  flush_cnt_q;
    logic                  load_use;

    // A load in EX whose result the ID instruction actually reads; x0 never hazards.
    assign load_use = ctrl_q.valid && (ctrl_q.opcode == OPCODE_LOAD) && (ctrl_q.rd != 5'd0)
                   && id_valid_ip
                   && ((uses_rs1(id_opcode_ip) && (id_rs1_ip == ctrl_q.rd))
                    || (uses_rs2(id_opcode_ip) && (id_rs2_ip == ctrl_q.rd)));

    // A flush kills the ID instruction anyway, so holding the front end would be wrong.
    assign stall_op = !flush_ip && (hold_ip || load_use);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush_ip) begin
            ctrl_q     <= BUBBLE_CTRL;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else if (!hold_ip) begin
            if (load_use || !id_valid_ip) begin
                ctrl_q     <= BUBBLE_CTRL;
                imm_q      <= '0;
                pc_q       <= '0;
                rs1_data_q <= '0;
                rs2_data_q <= '0;
            end else begin
                ctrl_q.valid  <= 1'b1;
                ctrl_q.opcode <= id_opcode_ip;
                ctrl_q.rs1    <= id_rs1_ip;
                ctrl_q.rs2    <= id_rs2_ip;
                ctrl_q.rd     <= id_rd_ip;
                ctrl_q.wb_mux <= id_wb_mux_ip;
                imm_q         <= id_imm_ip;
                pc_q          <= id_pc_ip;
                rs1_data_q    <= id_rs1_data_ip;
                rs2_data_q    <= id_rs2_data_ip;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_op && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush_ip && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .sel           (fa_mux_ip),
        .reg_data      (rs1_data_q),
        .ex_mem_result (ex_mem_result_ip),
        .mem_wb_result (mem_wb_result_ip),
        .operand       (ex_rs1_val_op)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .sel           (fb_mux_ip),
        .reg_data      (rs2_data_q),
        .ex_mem_result (ex_mem_result_ip),
        .mem_wb_result (mem_wb_result_ip),
        .operand       (ex_rs2_val_op)
    );

    assign ex_valid_op  = ctrl_q.valid;
    assign ex_opcode_op = ctrl_q.opcode;
    assign ex_rs1_op    = ctrl_q.rs1;
    assign ex_rs2_op    = ctrl_q.rs2;
    assign ex_rd_op     = ctrl_q.rd;
    assign ex_wb_mux_op = ctrl_q.wb_mux;
    assign ex_imm_op    = imm_q;
    assign ex_pc_op     = pc_q;
    assign stall_cnt_op = stall_cnt_q;
    assign flush_cnt_op = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus random traffic
// checked against a cycle-level behavioural model of the ID/EX stage.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   id_valid_ip;
    logic [6:0]             id_opcode_ip;
    logic [4:0]             id_rs1_ip, id_rs2_ip, id_rd_ip;
    logic [XLEN-1:0]        id_rs1_data_ip, id_rs2_data_ip, id_imm_ip, id_pc_ip;
    write_back_mux_selector id_wb_mux_ip;
    logic                   flush_ip, hold_ip;
    forward_mux_code        fa_mux_ip, fb_mux_ip;
    logic [XLEN-1:0]        ex_mem_result_ip, mem_wb_result_ip;
    logic                   ex_valid_op;
    logic [6:0]             ex_opcode_op;
    logic [4:0]             ex_rs1_op, ex_rs2_op, ex_rd_op;
    write_back_mux_selector ex_wb_mux_op;
    logic [XLEN-1:0]        ex_imm_op, ex_pc_op, ex_rs1_val_op, ex_rs2_val_op;
    logic                   stall_op;
    logic [CNT_W-1:0]       stall_cnt_op, flush_cnt_op;

    id_ex_stage #(.XLEN(XLEN), .CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid_ip(id_valid_ip), .id_opcode_ip(id_opcode_ip),
        .id_rs1_ip(id_rs1_ip), .id_rs2_ip(id_rs2_ip), .id_rd_ip(id_rd_ip),
        .id_rs1_data_ip(id_rs1_data_ip), .id_rs2_data_ip(id_rs2_data_ip),
        .id_imm_ip(id_imm_ip), .id_pc_ip(id_pc_ip), .id_wb_mux_ip(id_wb_mux_ip),
        .flush_ip(flush_ip), .hold_ip(hold_ip),
        .fa_mux_ip(fa_mux_ip), .fb_mux_ip(fb_mux_ip),
        .ex_mem_result_ip(ex_mem_result_ip), .mem_wb_result_ip(mem_wb_result_ip),
        .ex_valid_op(ex_valid_op), .ex_opcode_op(ex_opcode_op),
        .ex_rs1_op(ex_rs1_op), .ex_rs2_op(ex_rs2_op), .ex_rd_op(ex_rd_op),
        .ex_wb_mux_op(ex_wb_mux_op), .ex_imm_op(ex_imm_op), .ex_pc_op(ex_pc_op),
        .ex_rs1_val_op(ex_rs1_val_op), .ex_rs2_val_op(ex_rs2_val_op),
        .stall_op(stall_op), .stall_cnt_op(stall_cnt_op), .flush_cnt_op(flush_cnt_op)
    );

    always #5 clk = ~clk;

    // Architectural view of what EX should hold, plus plain integer counters.
    typedef struct {
        bit        valid;
        bit [6:0]  opcode;
        bit [4:0]  rs1, rs2, rd;
        bit [1:0]  wb;
        bit [31:0] imm, pc, d1, d2;
        int        scnt, fcnt;
    } model_t;

    typedef struct {
        bit        valid;
        bit [6:0]  opcode;
        bit [4:0]  rs1, rs2, rd;
        bit [1:0]  wb;
        bit [31:0] imm, pc, rs1_val, rs2_val;
        bit        stall;
        int        scnt, fcnt;
    } exp_t;

    model_t m;
    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     pushed  = 0;
    int     popped  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit reads_rs1(input bit [6:0] op);
        return op inside {OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR};
    endfunction

    function automatic bit reads_rs2(input bit [6:0] op);
        return op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    endfunction

    function automatic bit [31:0] pick(input bit [1:0] code, input bit [31:0] exr,
                                       input bit [31:0] wbr, input bit [31:0] regv);
        if (code == 2'd1) return exr;
        if (code == 2'd2) return wbr;
        return regv;
    endfunction

    function automatic void empty_ex(inout model_t s);
        s.valid = 0; s.opcode = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.wb = 0;
        s.imm = 0; s.pc = 0; s.d1 = 0; s.d2 = 0;
    endfunction

    // Drives one cycle of ID/control inputs, records the expected outputs for
    // that cycle and advances the model across the following rising edge.
    task automatic apply(input bit rst, input bit v, input bit [6:0] op,
                         input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                         input bit fl, input bit hd, input bit [1:0] fa, input bit [1:0] fb,
                         input bit [31:0] exr, input bit [31:0] wbr);
        exp_t      e;
        bit        hazard;
        bit [31:0] d1, d2, imm, pc;
        bit [1:0]  wb;
        d1 = $urandom; d2 = $urandom; imm = $urandom; pc = $urandom & 32'hFFFF_FFFC;
        wb = 2'($urandom_range(0, 3));
        @(negedge clk);
        reset = rst; id_valid_ip = v; id_opcode_ip = op;
        id_rs1_ip = r1; id_rs2_ip = r2; id_rd_ip = rd;
        id_rs1_data_ip = d1; id_rs2_data_ip = d2; id_imm_ip = imm; id_pc_ip = pc;
        id_wb_mux_ip = write_back_mux_selector'(wb);
        flush_ip = fl; hold_ip = hd;
        fa_mux_ip = forward_mux_code'(fa); fb_mux_ip = forward_mux_code'(fb);
        ex_mem_result_ip = exr; mem_wb_result_ip = wbr;
        #1;
        hazard = m.valid && m.opcode == OPCODE_LOAD && m.rd != 0 && v
              && ((reads_rs1(op) && r1 == m.rd) || (reads_rs2(op) && r2 == m.rd));
        e.valid = m.valid; e.opcode = m.opcode; e.rs1 = m.rs1; e.rs2 = m.rs2; e.rd = m.rd;
        e.wb = m.wb; e.imm = m.imm; e.pc = m.pc;
        e.rs1_val = pick(fa, exr, wbr, m.d1);
        e.rs2_val = pick(fb, exr, wbr, m.d2);
        e.stall = !fl && (hd || hazard);
        e.scnt = m.scnt; e.fcnt = m.fcnt;
        sb.push_back(e);
        pushed++;
        if (rst) begin
            empty_ex(m);
            m.scnt = 0; m.fcnt = 0;
        end else begin
            m.scnt = (m.scnt + int'(e.stall) > CNT_MAX) ? CNT_MAX : m.scnt + int'(e.stall);
            m.fcnt = (m.fcnt + int'(fl) > CNT_MAX) ? CNT_MAX : m.fcnt + int'(fl);
            if (fl || (!hd && (hazard || !v))) begin
                empty_ex(m);
            end else if (!hd) begin
                m.valid = 1; m.opcode = op; m.rs1 = r1; m.rs2 = r2; m.rd = rd; m.wb = wb;
                m.imm = imm; m.pc = pc; m.d1 = d1; m.d2 = d2;
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                check("ex_valid",   ex_valid_op,   e.valid);
                check("ex_opcode",  ex_opcode_op,  e.opcode);
                check("ex_rs1",     ex_rs1_op,     e.rs1);
                check("ex_rs2",     ex_rs2_op,     e.rs2);
                check("ex_rd",      ex_rd_op,      e.rd);
                check("ex_wb_mux",  ex_wb_mux_op,  e.wb);
                check("ex_imm",     ex_imm_op,     e.imm);
                check("ex_pc",      ex_pc_op,      e.pc);
                check("ex_rs1_val", ex_rs1_val_op, e.rs1_val);
                check("ex_rs2_val", ex_rs2_val_op, e.rs2_val);
                check("stall",      stall_op,      e.stall);
                check("stall_cnt",  stall_cnt_op,  e.scnt[CNT_W-1:0]);
                check("flush_cnt",  flush_cnt_op,  e.fcnt[CNT_W-1:0]);
            end
        end
    end

    initial begin
        bit [4:0] regs [4];
        bit [6:0] ops [10];
        int       drain;
        regs = '{5'd0, 5'd1, 5'd2, 5'd5};
        ops  = '{OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
                 OPCODE_LOAD, OPCODE_STORE, OPCODE_OPIMM, OPCODE_OP, 7'h7F};
        empty_ex(m);
        m.scnt = 0; m.fcnt = 0;
        reset = 1; id_valid_ip = 0; id_opcode_ip = 0; id_rs1_ip = 0; id_rs2_ip = 0;
        id_rd_ip = 0; id_rs1_data_ip = 0; id_rs2_data_ip = 0; id_imm_ip = 0; id_pc_ip = 0;
        id_wb_mux_ip = NO_WRITEBACK; flush_ip = 0; hold_ip = 0;
        fa_mux_ip = NO_FORWARD_SELECT; fb_mux_ip = NO_FORWARD_SELECT;
        ex_mem_result_ip = 0; mem_wb_result_ip = 0;

        // Reset, then idle with no valid instruction.
        repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // lw x5,0(x1); add x6,x5,x2 -> one bubble, then forward from WB.
        apply(0, 1, OPCODE_LOAD, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_OP,   5, 2, 6, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_OP,   5, 2, 6, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 32'h1234_5678, 32'hDEAD_BEEF);

        // Load to x0 and an unused rs2 match must not stall.
        apply(0, 1, OPCODE_LOAD,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_OP,    0, 2, 6, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_LOAD,  1, 0, 5, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_OPIMM, 6, 5, 7, 0, 0, 0, 0, 0, 0);

        // Flush concurrent with a load-use hazard.
        apply(0, 1, OPCODE_LOAD, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_OP,   5, 2, 6, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // sub x8,x3,x4 in EX, then hold three cycles with rs2 forwarded from EX/MEM.
        apply(0, 1, OPCODE_OP, 3, 4, 8, 0, 0, 0, 0, 0, 0);
        repeat (3) apply(0, 1, OPCODE_OP, 8, 9, 10, 0, 1, 0, 1, 32'h0000_0010, 0);
        apply(0, 1, OPCODE_OP, 8, 9, 10, 0, 0, 0, 1, 32'h0000_0010, 0);

        // Hold with a pending load-use: hold wins, hazard re-evaluated afterwards.
        apply(0, 1, OPCODE_LOAD,  1, 0, 5, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_STORE, 2, 5, 0, 0, 1, 0, 0, 0, 0);
        apply(0, 1, OPCODE_STORE, 2, 5, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, OPCODE_STORE, 2, 5, 0, 0, 0, 2, 0, 0, 0);

        // Saturate stall_cnt with a long hold, then reset in the middle of the hold.
        repeat (CNT_MAX + 20) apply(0, 1, OPCODE_OP, 1, 2, 3, 0, 1, 0, 0, 0, 0);
        apply(1, 1, OPCODE_OP, 1, 2, 3, 0, 1, 0, 0, 0, 0);
        repeat (2) apply(0, 1, OPCODE_OP, 1, 2, 3, 0, 1, 0, 0, 0, 0);

        // Random traffic with a small register pool so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 85),
                  ops[$urandom_range(0, 9)],
                  regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                  ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 15),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom);
        end

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #5;
        check("scoreboard_drain", popped, pushed);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
